// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver; rx -> o_data/o_valid (i_ready handshake), o_ferr/o_oerr one-cycle error pulses
module serial_rx #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_ferr,
  output logic       o_oerr
);
  localparam int BAUD_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLKS = BAUD_CLKS / 2;
  localparam int CW = $clog2(BAUD_CLKS);
  generate
    if (HALF_CLKS < 2) begin : g_bad
      $error("serial_rx: HALF_CLKS must be at least 2");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t st;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic rx_s, take, last_baud;
  assign rx_s = sync[1];
  assign take = o_valid && i_ready;
  assign last_baud = cnt == CW'(BAUD_CLKS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_valid <= 1'b0;
      o_data <= 8'h00;
      o_ferr <= 1'b0;
      o_oerr <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      o_ferr <= 1'b0;
      o_oerr <= 1'b0;
      if (take) o_valid <= 1'b0;
      case (st)
        IDLE:
          if (!rx_s) begin
            st <= START;
            cnt <= '0;
          end
        START:
          if (cnt == CW'(HALF_CLKS - 1)) begin
            st <= rx_s ? IDLE : DATA;
            cnt <= '0;
            idx <= '0;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (last_baud) begin
            sh <= {rx_s, sh[7:1]};
            cnt <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) st <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (last_baud) begin
            cnt <= '0;
            if (rx_s) begin
              st <= IDLE;
              if (!o_valid || i_ready) begin
                o_valid <= 1'b1;
                o_data <= sh;
              end else o_oerr <= 1'b1;
            end else begin
              st <= BREAK;
              o_ferr <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        BREAK: if (rx_s) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized self-checking bench for serial_rx with a byte-level buffer model
module tb_serial_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, i_ready = 1'b0;
  logic o_valid, o_ferr, o_oerr;
  logic [7:0] o_data;
  int checks = 0, failures = 0, cyc = 0;
  int n_ferr = 0, n_oerr = 0, n_load = 0, rise_cyc = -1;
  typedef struct {int c; logic [7:0] b; logic ok;} ev_t;
  ev_t evq[$];
  ev_t ev;
  logic [7:0] got[$];
  logic mv = 1'b0, pv = 1'b0, take, fe, oe, mv_old;
  logic [7:0] md = 8'h00, pd = 8'h00;
  serial_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ferr(o_ferr), .o_oerr(o_oerr)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      mv = 1'b0;
      md = 8'h00;
      evq.delete();
      checks++;
      if ({o_valid, o_data, o_ferr, o_oerr} !== 11'd0) begin
        failures++;
        $display("FAIL in_reset cycle %0d: v=%b d=%h fe=%b oe=%b, expected all 0", cyc, o_valid, o_data, o_ferr, o_oerr);
      end
    end else begin
      take = mv && i_ready;
      mv_old = mv;
      fe = 1'b0;
      oe = 1'b0;
      if (take) mv = 1'b0;
      if (evq.size() > 0 && evq[0].c == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) fe = 1'b1;
        else if (!mv_old || take) begin
          mv = 1'b1;
          md = ev.b;
          n_load++;
        end else oe = 1'b1;
      end
      if (pv && i_ready) got.push_back(pd);
      if (!pv && o_valid) rise_cyc = cyc;
      n_ferr += int'(o_ferr);
      n_oerr += int'(o_oerr);
      checks++;
      if ({o_valid, o_data, o_ferr, o_oerr} !== {mv, md, fe, oe}) begin
        failures++;
        if (failures <= 20)
          $display("FAIL model cycle %0d: got v=%b d=%h fe=%b oe=%b, expected v=%b d=%h fe=%b oe=%b",
                   cyc, o_valid, o_data, o_ferr, o_oerr, mv, md, fe, oe);
      end
    end
    pv = o_valid;
    pd = o_data;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  // E0 is the next posedge; the stop bit is sampled 154 edges after E0
  task automatic send(input logic [7:0] b, input logic stop);
    evq.push_back('{cyc + 155, b, stop});
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      tick(16);
    end
  endtask
  task automatic drain();
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    tick(1);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    tick(3);
    checks++;
    if ({o_valid, o_data, o_ferr, o_oerr} !== 11'd0) begin failures++; $display("FAIL reset_outputs: v=%b d=%h fe=%b oe=%b, expected all 0", o_valid, o_data, o_ferr, o_oerr); end
    rst = 1'b0;
    tick(1000);
    checks++;
    if (o_valid !== 1'b0 || got.size() != 0 || n_ferr != 0) begin failures++; $display("FAIL reset_idle: v=%b transfers=%0d ferr=%0d, expected 0/0/0", o_valid, got.size(), n_ferr); end
  endtask
  task automatic test_single();
    int s, g0;
    g0 = got.size();
    i_ready = 1'b0;
    s = cyc;
    send(8'h55, 1'b1);
    tick(5);
    checks++;
    if (rise_cyc != s + 155) begin failures++; $display("FAIL single_latency: rise at %0d, expected %0d", rise_cyc, s + 155); end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h55) begin failures++; $display("FAIL single_data: v=%b d=%h, expected 1/55", o_valid, o_data); end
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL single_consume: v=%b, expected 0", o_valid); end
    tick(1);
    checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h55 || n_ferr != 0 || n_oerr != 0) begin failures++; $display("FAIL single_transfer: n=%0d ferr=%0d oerr=%0d, expected 1 transfer of 55, no flags", got.size() - g0, n_ferr, n_oerr); end
  endtask
  task automatic test_glitch();
    int f0;
    f0 = n_ferr;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    checks++;
    if (o_valid !== 1'b0 || n_ferr != f0) begin failures++; $display("FAIL glitch_ignored: v=%b ferr=%0d, expected 0/%0d", o_valid, n_ferr, f0); end
    send(8'hA3, 1'b1);
    tick(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA3) begin failures++; $display("FAIL glitch_next: v=%b d=%h, expected 1/a3", o_valid, o_data); end
    drain();
  endtask
  task automatic test_framing();
    int f0;
    f0 = n_ferr;
    send(8'hA5, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(10);
    checks++;
    if (n_ferr != f0 + 1 || o_valid !== 1'b0) begin failures++; $display("FAIL ferr_pulse: ferr=%0d v=%b, expected %0d/0", n_ferr, o_valid, f0 + 1); end
    send(8'h3C, 1'b1);
    tick(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin failures++; $display("FAIL ferr_recover: v=%b d=%h, expected 1/3c", o_valid, o_data); end
    drain();
  endtask
  task automatic test_overrun();
    int o0, g0;
    o0 = n_oerr;
    i_ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h11 || n_oerr != o0 + 1) begin failures++; $display("FAIL overrun_hold: v=%b d=%h oerr=%0d, expected 1/11/%0d", o_valid, o_data, n_oerr, o0 + 1); end
    drain();
    checks++;
    if (got[got.size()-1] !== 8'h11) begin failures++; $display("FAIL overrun_byte: got %h, expected 11", got[got.size()-1]); end
    o0 = n_oerr;
    g0 = got.size();
    i_ready = 1'b1;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(3);
    i_ready = 1'b0;
    tick(1);
    checks++;
    if (got.size() != g0 + 2 || n_oerr != o0 || o_valid !== 1'b0) begin failures++; $display("FAIL b2b_count: transfers=%0d oerr=%0d v=%b, expected 2/%0d/0", got.size() - g0, n_oerr, o_valid, o0); end
    else begin
      checks++;
      if (got[g0] !== 8'h11 || got[g0+1] !== 8'h22) begin failures++; $display("FAIL b2b_order: got %h %h, expected 11 22", got[g0], got[g0+1]); end
    end
  endtask
  task automatic test_reset_mid();
    int g0, f0, o0;
    fork
      send(8'hFF, 1'b1);
      begin
        tick(16 * 5 + 4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    join
    tick(5);
    g0 = got.size();
    f0 = n_ferr;
    o0 = n_oerr;
    send(8'h42, 1'b1);
    tick(2);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h42 || n_ferr != f0 || n_oerr != o0) begin failures++; $display("FAIL reset_mid: v=%b d=%h ferr=%0d oerr=%0d, expected 1/42/%0d/%0d", o_valid, o_data, n_ferr, n_oerr, f0, o0); end
    drain();
    checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h42) begin failures++; $display("FAIL reset_mid_only: transfers=%0d, expected exactly one 42", got.size() - g0); end
  endtask
  task automatic test_random();
    int g0, l0, r;
    logic ok;
    logic done;
    done = 1'b0;
    g0 = got.size();
    l0 = n_load;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            rx = 1'b0;
            tick($urandom_range(1, 5));
            rx = 1'b1;
            tick($urandom_range(12, 20));
          end
          ok = r != 1;
          send(8'($urandom), ok);
          if (!ok) begin
            tick($urandom_range(0, 30));
            rx = 1'b1;
            tick($urandom_range(4, 8));
          end else tick($urandom_range(0, 3));
        end
        done = 1'b1;
      end
      while (!done) begin
        i_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    join
    i_ready = 1'b1;
    tick(3);
    i_ready = 1'b0;
    tick(1);
    checks++;
    if (got.size() - g0 != n_load - l0 || o_valid !== 1'b0) begin failures++; $display("FAIL random_delivered: transfers=%0d v=%b, expected %0d/0", got.size() - g0, o_valid, n_load - l0); end
  endtask
  initial begin
    tick(1);
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver that deserialises the Fomu's asynchronous 8N1 serial input into bytes and presents them on a valid/ready byte stream. It sits directly upstream of the character-echo stage: each accepted byte is one character read from the console. Start-bit glitches, framing errors and overruns are detected and reported without corrupting the buffered byte.

## Interface
- `CLK_FREQ`, 48_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: serial bit rate in bit/s.
- Derived, not overridable:
  - `BAUD_CLKS = CLK_FREQ / BAUD_RATE`, integer-truncated.
  - `HALF_CLKS = BAUD_CLKS / 2`, truncated.
  - Elaboration fails if `HALF_CLKS < 2`.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `o_valid`  out  1  `o_data` holds an unconsumed byte.
- `o_data`  out  8  received byte.
- `i_ready`  in  1  consumer accepts the byte this cycle.
- `o_ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `o_oerr`  out  1  one-cycle pulse: byte completed while buffer full; new byte dropped.

## Operation
- Reset values:
  - `o_valid=0`, `o_data=8'h00`, `o_ferr=0`, `o_oerr=0`.
  - State IDLE, counters 0.
  - Both synchroniser flops reset to 1.
- `rx` passes through a 2-flop synchroniser giving `rx_s`. The FSM sees only `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rx_s==0`, go to START and clear `cnt`.
  - **START:** increment `cnt`. At `cnt==HALF_CLKS-1`, sample `rx_s`:
    - If 0: go to DATA with `cnt=0`, `bit_idx=0`.
    - If 1: glitch; return to IDLE with no output or flag.
  - **DATA:** increment `cnt`. At `cnt==BAUD_CLKS-1`:
    - Shift `rx_s` into the shift register, LSB first.
    - Set `cnt=0` and increment `bit_idx`.
    - After bit 7, go to STOP.
  - **STOP:** at `cnt==BAUD_CLKS-1`, sample `rx_s`:
    - If 1: deliver the shift register to the buffer (rules below), then go to IDLE.
    - If 0: pulse `o_ferr`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from re-triggering.
- Output buffer is one entry (`o_valid`/`o_data`). A transfer occurs on an edge where `o_valid && i_ready`.
- Delivery on stop-bit success:
  - Buffer empty, or transferring this same edge: load `o_data`, set `o_valid=1`, no overrun.
  - Buffer full and not transferring: keep the old byte, drop the new one, pulse `o_oerr`.
- Transfer with no delivery on the same edge clears `o_valid`. `o_data` holds its last value.
- `o_valid` never drops without a transfer, except on reset.
- `o_data` is stable while `o_valid=1`.
- `i_ready` may be asserted when `o_valid=0`; it has no effect.

## Timing
- E0 is the first rising edge at which the first synchroniser flop captures `rx=0`.
  - E1: `rx_s=0`.
  - E2: FSM leaves IDLE.
  - Start-bit sample at E2+HALF_CLKS.
  - Data bit i sampled at E2+HALF_CLKS+(i+1)·BAUD_CLKS.
  - Stop bit sampled at E2+HALF_CLKS+9·BAUD_CLKS.
- Consequences, measured after edge E0+2+HALF_CLKS+9·BAUD_CLKS:
  - `o_valid`/`o_data` update.
  - `o_ferr` or `o_oerr` goes high for exactly one cycle.
- The FSM is back in IDLE on the edge after the stop sample. A start bit that follows the stop bit immediately is detected with no dead cycles beyond synchroniser latency.
- Consumer-side latency: `o_valid` falls the edge after a transfer when no new byte lands on that edge.
- Asynchronous reset mid-frame aborts immediately: no flag, partial byte lost, buffered byte lost. Reception restarts from IDLE after `rst` deasserts.

## Test plan
Bench parameters: `CLK_FREQ=16`, `BAUD_RATE=1`, so `BAUD_CLKS=16` and `HALF_CLKS=8`.
- **Reset:** assert `rst` with `rx=1` → all outputs 0 and FSM in IDLE. Hold `rx=1` for 1000 cycles → `o_valid` stays 0.
- **Single byte:** send 0x55, 16 clocks per bit, `i_ready=0` → `o_valid` rises after E0+154, `o_data=8'h55`, no flags. Pulse `i_ready` for one cycle → `o_valid=0` next edge.
- **Glitch:** drive `rx` low for 4 cycles, then high → no `o_valid`, no `o_ferr`. A following 0xA3 frame is received correctly.
- **Framing error:** send 0xA5 with the stop bit low, hold `rx` low 40 more cycles, then high → one-cycle `o_ferr`, `o_valid` stays 0. Subsequent 0x3C is received as 0x3C.
- **Overrun and back-to-back:**
  - With `i_ready=0`, send 0x11 then 0x22 with no gap → `o_data=8'h11` held, one `o_oerr` pulse at the second stop sample.
  - Repeat with `i_ready=1` → two transfers, 0x11 then 0x22, no `o_oerr`.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF, release, send 0x42 → only 0x42 delivered, no flags.
